// File: rtl/video_capture_writer.sv
// -----------------------------------------------------------------------------
// video_capture_writer
//
// Turns a pixel stream with raster counters into line-buffer RAM write cycles.
// A programmable capture window selects the pixels that are written. The
// window can skip a band of lines (the gap) and can keep only every second
// pixel (2:1 horizontal decimation). Each captured line is written at a line
// base address. The line base steps through a ring of cfg_numwords words.
// A one-cycle read-start trigger for the downstream scaler fires on the write
// to a chosen address.
//
// All cfg_* inputs are copied into shadow registers at reset and at each frame
// boundary. Between boundaries, firmware may rewrite cfg_* freely.
//
// Ports
//   clock             pixel clock, rising edge
//   reset             synchronous, active-high
//   pixel_in          pixel at (counter_x, counter_y)
//   counter_x/_y      raster position
//   cfg_h_start/_end  horizontal window [start, end)
//   cfg_v_start/_end  vertical window [start, end)
//   cfg_gap_start/_end excluded lines [start, end); off when start >= end
//   cfg_h_decimate    keep only even offsets from h_start
//   cfg_line_length   RAM words per buffered line
//   cfg_numwords      ring size in RAM words
//   cfg_trigger_addr  write address that fires starttrigger
//   cfg_trigger_lines trigger only while (y - v_start) < this
//   wren/wraddr/wrdata RAM write port, one cycle after the sampled input
//   starttrigger      pulse coincident with the triggering write
//   frame_start       pulse in the cycle after a frame boundary
//   overflow          sticky per frame: a column reached line_length
// -----------------------------------------------------------------------------
module video_capture_writer #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 15,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic [CNT_WIDTH-1:0]  counter_x,
  input  logic [CNT_WIDTH-1:0]  counter_y,
  input  logic [CNT_WIDTH-1:0]  cfg_h_start,
  input  logic [CNT_WIDTH-1:0]  cfg_h_end,
  input  logic [CNT_WIDTH-1:0]  cfg_v_start,
  input  logic [CNT_WIDTH-1:0]  cfg_v_end,
  input  logic [CNT_WIDTH-1:0]  cfg_gap_start,
  input  logic [CNT_WIDTH-1:0]  cfg_gap_end,
  input  logic                  cfg_h_decimate,
  input  logic [ADDR_WIDTH-1:0] cfg_line_length,
  input  logic [ADDR_WIDTH-1:0] cfg_numwords,
  input  logic [ADDR_WIDTH-1:0] cfg_trigger_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_trigger_lines,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] wraddr,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic                  starttrigger,
  output logic                  frame_start,
  output logic                  overflow
);

  // Shadow copies of the configuration
  logic [CNT_WIDTH-1:0]  h_start_q, h_end_q, v_start_q, v_end_q;
  logic [CNT_WIDTH-1:0]  gap_start_q, gap_end_q, trig_lines_q;
  logic                  decim_q;
  logic [ADDR_WIDTH-1:0] line_len_q, numwords_q, trig_addr_q;

  // Datapath state
  logic [CNT_WIDTH-1:0]  x_prev_q;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic                  trig_q, trig_d;
  logic                  fstart_q;
  logic                  ovf_q, ovf_d;

  // Raster events
  logic frame_evt, line_evt;
  assign frame_evt = (counter_x == '0) && (counter_y == '0) && (x_prev_q != '0);
  // Compare against the previous x so that a stalled counter sitting on
  // h_end still counts as a single line end.
  assign line_evt  = (counter_x == h_end_q) && (x_prev_q != h_end_q);

  // Vertical qualification
  logic gap_en, in_v, in_gap, vcap, gap_line;
  assign gap_en   = gap_start_q < gap_end_q;
  assign in_v     = (counter_y >= v_start_q) && (counter_y < v_end_q);
  assign in_gap   = gap_en && (counter_y >= gap_start_q) && (counter_y < gap_end_q);
  assign vcap     = in_v && !in_gap;
  assign gap_line = in_gap && in_v;

  // Horizontal qualification and column
  logic [CNT_WIDTH-1:0]  x_off, col_cnt;
  logic [ADDR_WIDTH-1:0] col;
  logic                  hcap;
  assign x_off   = counter_x - h_start_q;
  assign hcap    = (counter_x >= h_start_q) && (counter_x < h_end_q) &&
                   (!decim_q || !x_off[0]);
  assign col_cnt = decim_q ? (x_off >> 1) : x_off;

  if (CNT_WIDTH >= ADDR_WIDTH) begin : g_col_trunc
    assign col = col_cnt[ADDR_WIDTH-1:0];
  end else begin : g_col_ext
    assign col = {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, col_cnt};
  end

  logic                  capture, do_write, ovf_hit;
  logic [ADDR_WIDTH-1:0] addr_sum;
  logic [CNT_WIDTH-1:0]  y_off;
  assign capture  = vcap && hcap;
  assign do_write = capture && (col < line_len_q);
  assign ovf_hit  = capture && !(col < line_len_q);
  assign addr_sum = base_q + col;
  assign y_off    = counter_y - v_start_q;

  // Next line base. The sums are kept one and two bits wider than the
  // address, so a ring that ends near 2^ADDR_WIDTH cannot alias. A line
  // whose end would pass numwords restarts at 0, so every line is stored
  // contiguously.
  logic [ADDR_WIDTH:0]   nxt;
  logic [ADDR_WIDTH+1:0] nxt_end;
  logic [ADDR_WIDTH-1:0] base_adv;
  assign nxt      = {1'b0, base_q} + {1'b0, line_len_q};
  assign nxt_end  = {1'b0, nxt} + {2'b00, line_len_q};
  assign base_adv = (nxt_end > {2'b00, numwords_q}) ? '0 : nxt[ADDR_WIDTH-1:0];

  always_comb begin
    base_d = base_q;
    if (line_evt) begin
      if (vcap)          base_d = base_adv;
      else if (gap_line) base_d = base_q;
      else               base_d = '0;
    end
    // A frame boundary takes priority when h_end == 0 makes both events coincide.
    if (frame_evt) base_d = '0;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_hit)   ovf_d = 1'b1;
    if (frame_evt) ovf_d = 1'b0;
  end

  always_comb begin
    wren_d   = do_write;
    wraddr_d = do_write ? addr_sum : wraddr_q;
    wrdata_d = do_write ? pixel_in : wrdata_q;
    trig_d   = do_write && (addr_sum == trig_addr_q) && (y_off < trig_lines_q);
  end

  always_ff @(posedge clock) begin
    if (reset || frame_evt) begin
      h_start_q    <= cfg_h_start;
      h_end_q      <= cfg_h_end;
      v_start_q    <= cfg_v_start;
      v_end_q      <= cfg_v_end;
      gap_start_q  <= cfg_gap_start;
      gap_end_q    <= cfg_gap_end;
      decim_q      <= cfg_h_decimate;
      line_len_q   <= cfg_line_length;
      numwords_q   <= cfg_numwords;
      trig_addr_q  <= cfg_trigger_addr;
      trig_lines_q <= cfg_trigger_lines;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_prev_q <= '0;
      base_q   <= '0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      trig_q   <= 1'b0;
      fstart_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      x_prev_q <= counter_x;
      base_q   <= base_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      trig_q   <= trig_d;
      fstart_q <= frame_evt;
      ovf_q    <= ovf_d;
    end
  end

  assign wren         = wren_q;
  assign wraddr       = wraddr_q;
  assign wrdata       = wrdata_q;
  assign starttrigger = trig_q;
  assign frame_start  = fstart_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_video_capture_writer.sv
// -----------------------------------------------------------------------------
// tb_video_capture_writer
//
// Directed bench for video_capture_writer. The raster is 24 x 10 pixels.
// pixel_in is {y, x}, so each write identifies the pixel that produced it.
// For each frame, the expected writes {trigger, addr, data} are queued from
// hand-computed line bases. A negedge monitor compares each observed write
// against the queue.
// -----------------------------------------------------------------------------
module tb_video_capture_writer;
  localparam int DW = 24;
  localparam int AW = 15;
  localparam int CW = 12;
  localparam int EW = 1 + AW + DW;
  localparam int W  = 24;
  localparam int H  = 10;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [DW-1:0] pixel_in = '0;
  logic [CW-1:0] counter_x = '0, counter_y = '0;
  logic [CW-1:0] cfg_h_start, cfg_h_end, cfg_v_start, cfg_v_end;
  logic [CW-1:0] cfg_gap_start, cfg_gap_end, cfg_trigger_lines;
  logic          cfg_h_decimate;
  logic [AW-1:0] cfg_line_length, cfg_numwords, cfg_trigger_addr;
  logic          wren, starttrigger, frame_start, overflow;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;

  video_capture_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in),
    .counter_x(counter_x), .counter_y(counter_y),
    .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
    .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
    .cfg_gap_start(cfg_gap_start), .cfg_gap_end(cfg_gap_end),
    .cfg_h_decimate(cfg_h_decimate), .cfg_line_length(cfg_line_length),
    .cfg_numwords(cfg_numwords), .cfg_trigger_addr(cfg_trigger_addr),
    .cfg_trigger_lines(cfg_trigger_lines),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .starttrigger(starttrigger), .frame_start(frame_start), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [EW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            fs_cnt = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (frame_start) fs_cnt++;
      if (wren) begin
        // The written pixel must be the one applied exactly one cycle earlier.
        check("latency", {52'd0, wrdata[11:0]}, {52'd0, counter_x - 12'd1});
        if (exp_q.size() == 0) check("extra_write", {63'd0, wren}, 64'd0);
        else check("write", {24'd0, starttrigger, wraddr, wrdata}, {24'd0, exp_q.pop_front()});
      end else begin
        check("trig_idle", {63'd0, starttrigger}, 64'd0);
      end
    end
  end

  // driver tasks
  task automatic cycle(input int x, input int y);
    counter_x = x[CW-1:0];
    counter_y = y[CW-1:0];
    pixel_in  = {y[11:0], x[11:0]};
    @(posedge clock);
    #1;
  endtask

  // Queue writes for one line. a0 is the address of the first captured x.
  task automatic exp_line(input int y, input int a0, input int x_lo, input int x_hi,
                          input int step, input int trig_x);
    int a;
    logic [EW-1:0] e;
    a = a0;
    for (int x = x_lo; x < x_hi; x += step) begin
      e = {(x == trig_x), a[AW-1:0], y[11:0], x[11:0]};
      exp_q.push_back(e);
      a++;
    end
  endtask

  task automatic run_frame(input string tag, input int exp_fs, input int chg_y, input int chg_hs);
    fs_cnt = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == chg_y && x == 0) cfg_h_start = chg_hs[CW-1:0];
        cycle(x, y);
      end
    end
    check({tag, "_missing"}, exp_q.size(), 0);
    check({tag, "_fstart"}, fs_cnt, exp_fs);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wren"}, {63'd0, wren}, 64'd0);
    check({tag, "_wraddr"}, {49'd0, wraddr}, 64'd0);
    check({tag, "_wrdata"}, {40'd0, wrdata}, 64'd0);
    check({tag, "_trig"}, {63'd0, starttrigger}, 64'd0);
    check({tag, "_fstart"}, {63'd0, frame_start}, 64'd0);
    check({tag, "_ovf"}, {63'd0, overflow}, 64'd0);
  endtask

  task automatic set_defaults();
    cfg_h_start = 12'd10;  cfg_h_end = 12'd20;
    cfg_v_start = 12'd5;   cfg_v_end = 12'd8;
    cfg_gap_start = 12'd0; cfg_gap_end = 12'd0;
    cfg_h_decimate = 1'b0;
    cfg_line_length = 15'd16; cfg_numwords = 15'd64;
    cfg_trigger_addr = 15'h7fff; cfg_trigger_lines = 12'd0;
  endtask

  initial begin
    set_defaults();
    reset = 1'b1;
    cycle(0, 0); cycle(0, 0); cycle(0, 0);
    check_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // basic window: bases 0, 16, 32
    exp_line(5, 0, 10, 20, 1, -1);
    exp_line(6, 16, 10, 20, 1, -1);
    exp_line(7, 32, 10, 20, 1, -1);
    run_frame("basic", 0, -1, 0);
    check("basic_ovf", {63'd0, overflow}, 64'd0);

    // ring wrap: 32+16 > 40, so the third line restarts at 0
    cfg_numwords = 15'd40;
    exp_line(5, 0, 10, 20, 1, -1);
    exp_line(6, 16, 10, 20, 1, -1);
    exp_line(7, 0, 10, 20, 1, -1);
    run_frame("wrap", 1, -1, 0);

    // gap line 6 inside v 5..9: no writes there, base holds
    cfg_numwords = 15'd64; cfg_v_end = 12'd9;
    cfg_gap_start = 12'd6; cfg_gap_end = 12'd7;
    exp_line(5, 0, 10, 20, 1, -1);
    exp_line(7, 16, 10, 20, 1, -1);
    exp_line(8, 32, 10, 20, 1, -1);
    run_frame("gap", 1, -1, 0);

    // decimation: x = 10,12,14,16,18 at base+0..4
    cfg_gap_start = 12'd0; cfg_gap_end = 12'd0; cfg_v_end = 12'd8;
    cfg_h_decimate = 1'b1;
    exp_line(5, 0, 10, 20, 2, -1);
    exp_line(6, 16, 10, 20, 2, -1);
    exp_line(7, 32, 10, 20, 2, -1);
    run_frame("decim", 1, -1, 0);
    check("decim_ovf", {63'd0, overflow}, 64'd0);

    // line_length 3: x = 16,18 suppressed, bases 0, 3, 6, overflow sticks
    cfg_line_length = 15'd3;
    exp_line(5, 0, 10, 16, 2, -1);
    exp_line(6, 3, 10, 16, 2, -1);
    exp_line(7, 6, 10, 16, 2, -1);
    run_frame("ovf", 1, -1, 0);
    check("ovf_set", {63'd0, overflow}, 64'd1);

    // trigger on address 17 (line 6, x = 11) while y - v_start < 2
    cfg_h_decimate = 1'b0; cfg_line_length = 15'd16;
    cfg_trigger_addr = 15'd17; cfg_trigger_lines = 12'd2;
    exp_line(5, 0, 10, 20, 1, -1);
    exp_line(6, 16, 10, 20, 1, 11);
    exp_line(7, 32, 10, 20, 1, -1);
    run_frame("trig2", 1, -1, 0);
    check("ovf_clr", {63'd0, overflow}, 64'd0);

    // trigger_lines 1: line 6 no longer qualifies
    cfg_trigger_lines = 12'd1;
    exp_line(5, 0, 10, 20, 1, -1);
    exp_line(6, 16, 10, 20, 1, -1);
    exp_line(7, 32, 10, 20, 1, -1);
    run_frame("trig1", 1, -1, 0);

    // h_start rewritten on line 3: ignored for the rest of this frame
    exp_line(5, 0, 10, 20, 1, -1);
    exp_line(6, 16, 10, 20, 1, -1);
    exp_line(7, 32, 10, 20, 1, -1);
    run_frame("hold_cfg", 1, 3, 12);

    // next frame uses h_start 12
    exp_line(5, 0, 12, 20, 1, -1);
    exp_line(6, 16, 12, 20, 1, -1);
    exp_line(7, 32, 12, 20, 1, -1);
    run_frame("new_cfg", 1, -1, 0);

    // reset asserted at line 6, x = 15: the in-flight write drops, base restarts at 0
    exp_line(5, 0, 12, 20, 1, -1);
    exp_line(6, 16, 12, 15, 1, -1);
    exp_line(6, 4, 16, 20, 1, -1);
    exp_line(7, 16, 12, 20, 1, -1);
    fs_cnt = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == 6 && x == 15) begin
          reset = 1'b1;
          cycle(x, y);
          reset = 1'b0;
          check_zero("midreset");
        end else begin
          cycle(x, y);
        end
      end
    end
    check("midreset_missing", exp_q.size(), 0);
    check("midreset_fstart", fs_cnt, 1);
    exp_q.delete();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_capture_writer.md
Name: video_capture_writer

Overview:
- Parametrised successor of the pixel-to-framebuffer writer in the Dreamcast capture path.
- Takes pixel data plus raster counters, selects a programmable capture window with an optional vertical gap and optional 2:1 horizontal decimation, and generates line-buffer RAM write cycles.
- Emits a one-shot read-start trigger for the output scaler.
- All window/buffer config is shadowed at frame boundaries, so firmware may rewrite it at any time.

Parameters:
- DATA_WIDTH, 24, pixel word width (e.g. RGB888).
- ADDR_WIDTH, 15, RAM word-address width.
- CNT_WIDTH, 12, raster counter and window-config width.

Ports:
- clock  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pixel_in  in  DATA_WIDTH  pixel at (counter_x, counter_y).
- counter_x  in  CNT_WIDTH  horizontal raster position.
- counter_y  in  CNT_WIDTH  vertical raster position.
- cfg_h_start, cfg_h_end  in  CNT_WIDTH  horizontal window [start, end).
- cfg_v_start, cfg_v_end  in  CNT_WIDTH  vertical window [start, end).
- cfg_gap_start, cfg_gap_end  in  CNT_WIDTH  excluded lines [start, end); disabled when start >= end.
- cfg_h_decimate  in  1  capture only even offsets from h_start.
- cfg_line_length  in  ADDR_WIDTH  RAM words per buffered line.
- cfg_numwords  in  ADDR_WIDTH  total RAM words (ring size).
- cfg_trigger_addr  in  ADDR_WIDTH  write address that fires starttrigger.
- cfg_trigger_lines  in  CNT_WIDTH  trigger only while (y - v_start) < this.
- wren  out  1  RAM write enable.
- wraddr  out  ADDR_WIDTH  RAM write address.
- wrdata  out  DATA_WIDTH  RAM write data.
- starttrigger  out  1  one-cycle pulse, coincident with the triggering write.
- frame_start  out  1  one-cycle pulse after each frame-boundary event.
- overflow  out  1  sticky; column exceeded line_length this frame.

Behaviour:
- Reset (reset=1 at an edge): wren, starttrigger, frame_start, overflow = 0; wraddr, wrdata = 0; line base = 0; x_prev = 0; shadow registers load all cfg_* inputs. A write in flight is dropped.
- Frame-boundary event: counter_x==0 && counter_y==0 && x_prev!=0. On the event:
  - shadow registers reload from cfg_*;
  - line base <= 0; overflow <= 0;
  - frame_start=1 in the next cycle.
- Between events, cfg_* changes are ignored. All conditions below use shadow values.
- vcap(y): y>=v_start && y<v_end && !(gap enabled && y>=gap_start && y<gap_end).
- Gap line: gap enabled && gap_start<=y<gap_end && v_start<=y<v_end.
- hcap(x): x>=h_start && x<h_end && (!h_decimate || (x-h_start)[0]==0).
- Column: col = h_decimate ? (x-h_start)>>1 : (x-h_start). Computed at CNT_WIDTH, zero-extended or truncated to ADDR_WIDTH.
- Capture cycle: vcap && hcap.
  - If col < line_length: wren=1, wraddr=base+col (mod 2^ADDR_WIDTH), wrdata=pixel_in.
  - Else: wren=0 and overflow<=1.
- Latency is exactly 1 cycle: inputs sampled at edge n appear on wren/wraddr/wrdata at edge n+1. Non-capture cycles give wren=0; wraddr and wrdata hold their last values.
- starttrigger=1 on the same output cycle as a write whose wraddr==trigger_addr and (y-v_start)<trigger_lines. Otherwise 0.
- Line-end event: counter_x==h_end && x_prev!=h_end, i.e. once per line even if counter_x stalls. On the event:
  - vcap(y): nxt=base+line_length; base <= (nxt+line_length > numwords) ? 0 : nxt. This wrap keeps a whole line inside the ring.
  - Gap line: base holds.
  - Otherwise: base <= 0.
- Frame-boundary and line-end are never simultaneous when h_end>0. If h_end==0 both fire on the same cycle and frame-boundary wins (base=0).
- The sum base+line_length is computed at ADDR_WIDTH+1 bits, so there is no wrap error near 2^ADDR_WIDTH.

Test Plan:
- Defaults, h 10..20, v 5..8, line_length 16, numwords 64, no gap/decimate → 10 writes per line. Line 5 addresses 0..9, line 6 addresses 16..25, line 7 addresses 32..41. wrdata equals pixel_in delayed exactly 1 cycle.
- numwords 40, line_length 16, 3 captured lines → bases 0, 16, 0. The third line wraps because 32+16>40.
- Gap 6..7 inside v 5..9 → line 6 produces no writes and base holds. Line 7 writes at 16..25.
- h_decimate=1, h 10..20 → 5 writes per line at x=10,12,14,16,18 to addresses base+0..4. Then line_length 3 → x=16,18 suppressed and overflow=1; overflow clears at the next frame boundary.
- trigger_addr 17, trigger_lines 2 → starttrigger pulses once, on the write with wraddr 17 (line 6, x=11). Rerun with trigger_lines 1 → no pulse.
- Change cfg_h_start mid-frame → no effect until the frame boundary, after which frame_start pulses and the new window applies. Assert reset mid-line → all outputs 0 next cycle and base 0 afterwards.
